lookahead_borrow_subtractor_serial: RTL and testbench



---
 rtl/lookahead_borrow_subtractor_serial_pkg.sv | 23 ++
 rtl/lookahead_borrow_subtractor_serial_nibble.sv | 29 ++
 rtl/lookahead_borrow_subtractor_serial.sv | 141 ++++++++++++++
 tb/tb_lookahead_borrow_subtractor_serial.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/lookahead_borrow_subtractor_serial_pkg.sv
// Shared types and constants for the nibble-serial borrow-lookahead subtractor.
package lookahead_borrow_subtractor_serial_pkg;

    localparam int unsigned NIBBLE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef struct packed {
        logic borrow;
        logic overflow;
        logic zero;
    } flags_t;

    // Nibble index width; a single-nibble build still needs a 1-bit index.
    function automatic int unsigned idx_width(input int unsigned nibbles);
        return (nibbles > 1) ? $clog2(nibbles) : 1;
    endfunction

endpackage

// File: rtl/lookahead_borrow_subtractor_serial_nibble.sv
// 4-bit borrow-lookahead subtract slice: d = a - b - bin, bout = borrow out.
module borrow_lookahead_nibble (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       bin,
    output logic [3:0] d,
    output logic       bout
);

    logic [3:0] g;
    logic [3:0] p;
    logic [3:0] c;

    assign g = ~a & b;
    assign p = ~(a ^ b);

    // Every bit borrow is a flat sum of products on g/p/bin, no ripple path.
    assign c[0] = bin;
    assign c[1] = g[0] | (p[0] & bin);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & bin);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                | (p[2] & p[1] & p[0] & bin);
    assign bout = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                | (p[3] & p[2] & p[1] & g[0])
                | (p[3] & p[2] & p[1] & p[0] & bin);

    assign d = a ^ b ^ c;

endmodule

// File: rtl/lookahead_borrow_subtractor_serial.sv
// Multi-cycle a - b over WIDTH bits, one borrow-lookahead nibble per clock, LSB first,
// with valid/ready handshakes and registered borrow/overflow/zero flags.
module lookahead_borrow_subtractor_serial
    import lookahead_borrow_subtractor_serial_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out,
    output logic             overflow,
    output logic             zero
);

    localparam int unsigned NIBBLES = WIDTH / NIBBLE_W;
    localparam int unsigned IDX_W   = idx_width(NIBBLES);
    localparam int unsigned MSB     = WIDTH - 1;

    if ((WIDTH % NIBBLE_W) != 0 || WIDTH < NIBBLE_W) begin : g_bad_width
        $error("WIDTH must be a non-zero multiple of 4");
    end

    state_t             state;
    state_t             state_d;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;
    logic [WIDTH-1:0]   a_d;
    logic [WIDTH-1:0]   b_d;
    logic [WIDTH-1:0]   diff_d;
    logic [IDX_W-1:0]   idx_q;
    logic [IDX_W-1:0]   idx_d;
    logic               borrow_q;
    logic               borrow_d;
    flags_t             flags_q;
    flags_t             flags_d;
    logic               in_ready_d;
    logic               out_valid_d;

    logic [NIBBLE_W-1:0] nib_a_c;
    logic [NIBBLE_W-1:0] nib_b_c;
    logic [NIBBLE_W-1:0] nib_d_c;
    logic                nib_bout_c;

    // Current slice operands selected by the nibble index.
    always_comb begin
        nib_a_c = a_q[idx_q * NIBBLE_W +: NIBBLE_W];
        nib_b_c = b_q[idx_q * NIBBLE_W +: NIBBLE_W];
    end

    borrow_lookahead_nibble u_nibble (
        .a    (nib_a_c),
        .b    (nib_b_c),
        .bin  (borrow_q),
        .d    (nib_d_c),
        .bout (nib_bout_c)
    );

    // Next-state, datapath and output decode.
    always_comb begin
        state_d  = state;
        a_d      = a_q;
        b_d      = b_q;
        idx_d    = idx_q;
        borrow_d = borrow_q;
        diff_d   = diff;
        flags_d  = flags_q;

        case (state)
            IDLE: begin
                if (in_valid) begin
                    a_d      = a;
                    b_d      = b;
                    borrow_d = 1'b0;
                    idx_d    = '0;
                    state_d  = RUN;
                end
            end
            RUN: begin
                diff_d[idx_q * NIBBLE_W +: NIBBLE_W] = nib_d_c;
                borrow_d = nib_bout_c;
                idx_d    = idx_q + IDX_W'(1);
                if (idx_q == IDX_W'(NIBBLES - 1)) begin
                    // Flags are taken from the completed result, including the last slice.
                    idx_d            = '0;
                    flags_d.borrow   = nib_bout_c;
                    flags_d.overflow = (a_q[MSB] != b_q[MSB]) & (diff_d[MSB] != a_q[MSB]);
                    flags_d.zero     = ~|diff_d;
                    state_d          = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        in_ready_d  = (state_d == IDLE);
        out_valid_d = (state_d == DONE);
    end

    // State and registered outputs; reset aborts any operation in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            a_q       <= '0;
            b_q       <= '0;
            idx_q     <= '0;
            borrow_q  <= 1'b0;
            diff      <= '0;
            flags_q   <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            state     <= state_d;
            a_q       <= a_d;
            b_q       <= b_d;
            idx_q     <= idx_d;
            borrow_q  <= borrow_d;
            diff      <= diff_d;
            flags_q   <= flags_d;
            in_ready  <= in_ready_d;
            out_valid <= out_valid_d;
        end
    end

    assign borrow_out = flags_q.borrow;
    assign overflow   = flags_q.overflow;
    assign zero       = flags_q.zero;

endmodule

// File: tb/tb_lookahead_borrow_subtractor_serial.sv
// Scoreboard bench: 16-bit directed vectors plus an exhaustive 4-bit build sweep.
module tb_lookahead_borrow_subtractor_serial;

    typedef struct {
        logic [15:0] d;
        logic        b;
        logic        o;
        logic        z;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic        in_valid16 = 1'b0;
    logic        in_ready16;
    logic [15:0] a16 = '0;
    logic [15:0] b16 = '0;
    logic        out_valid16;
    logic        out_ready16 = 1'b1;
    logic [15:0] diff16;
    logic        borrow16, ovf16, zero16;

    logic        in_valid4 = 1'b0;
    logic        in_ready4;
    logic [3:0]  a4 = '0;
    logic [3:0]  b4 = '0;
    logic        out_valid4;
    logic        out_ready4 = 1'b1;
    logic [3:0]  diff4;
    logic        borrow4, ovf4, zero4;

    exp_t q16[$];
    exp_t q4[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    lookahead_borrow_subtractor_serial #(.WIDTH(16)) dut16 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid16), .in_ready(in_ready16), .a(a16), .b(b16),
        .out_valid(out_valid16), .out_ready(out_ready16), .diff(diff16),
        .borrow_out(borrow16), .overflow(ovf16), .zero(zero16)
    );

    lookahead_borrow_subtractor_serial #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid4), .in_ready(in_ready4), .a(a4), .b(b4),
        .out_valid(out_valid4), .out_ready(out_ready4), .diff(diff4),
        .borrow_out(borrow4), .overflow(ovf4), .zero(zero4)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitors: pop an expectation on every output handshake.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && out_valid16 && out_ready16) begin
            if (q16.size() == 0) begin
                check("w16_unexpected_output", 32'(diff16), 32'hDEAD_BEEF);
            end else begin
                e = q16.pop_front();
                check("w16_diff",       32'(diff16),   32'(e.d));
                check("w16_borrow_out", 32'(borrow16), 32'(e.b));
                check("w16_overflow",   32'(ovf16),    32'(e.o));
                check("w16_zero",       32'(zero16),   32'(e.z));
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (!rst && out_valid4 && out_ready4) begin
            if (q4.size() == 0) begin
                check("w4_unexpected_output", 32'(diff4), 32'hDEAD_BEEF);
            end else begin
                e = q4.pop_front();
                check("w4_diff",       32'(diff4),   32'(e.d));
                check("w4_borrow_out", 32'(borrow4), 32'(e.b));
                check("w4_overflow",   32'(ovf4),    32'(e.o));
                check("w4_zero",       32'(zero4),   32'(e.z));
            end
        end
    end

    // Accept one op on the 16-bit unit; returns after the accept edge.
    task automatic send16(input logic [15:0] a, input logic [15:0] b);
        int n = 0;
        while (!in_ready16 && n < 50) begin tick(); n++; end
        check("w16_in_ready_before_accept", 32'(in_ready16), 32'd1);
        a16 = a; b16 = b; in_valid16 = 1'b1;
        tick();
        in_valid16 = 1'b0;
    endtask

    task automatic wait_valid16();
        int n = 0;
        while (!out_valid16 && n < 50) begin tick(); n++; end
        check("w16_latency", 32'(n), 32'd4);
    endtask

    task automatic issue16(input logic [15:0] a, input logic [15:0] b,
                           input logic [15:0] d, input logic bo, input logic ov, input logic z);
        exp_t e;
        e.d = d; e.b = bo; e.o = ov; e.z = z;
        q16.push_back(e);
        send16(a, b);
        wait_valid16();
        tick();
        check("w16_out_valid_after_hs", 32'(out_valid16), 32'd0);
        check("w16_in_ready_after_hs",  32'(in_ready16),  32'd1);
    endtask

    task automatic issue4(input logic [3:0] a, input logic [3:0] b,
                          input logic [3:0] d, input logic bo, input logic ov, input logic z);
        exp_t e;
        int n = 0;
        e.d = 16'(d); e.b = bo; e.o = ov; e.z = z;
        q4.push_back(e);
        while (!in_ready4 && n < 50) begin tick(); n++; end
        check("w4_in_ready_before_accept", 32'(in_ready4), 32'd1);
        a4 = a; b4 = b; in_valid4 = 1'b1;
        tick();
        in_valid4 = 1'b0;
        n = 0;
        while (!out_valid4 && n < 50) begin tick(); n++; end
        check("w4_latency", 32'(n), 32'd1);
        tick();
    endtask

    initial begin
        logic [3:0] md;
        repeat (3) tick();
        rst = 1'b0;
        check("rst_in_ready16",  32'(in_ready16),  32'd1);
        check("rst_out_valid16", 32'(out_valid16), 32'd0);
        check("rst_diff16",      32'(diff16),      32'd0);
        check("rst_flags16",     32'({borrow16, ovf16, zero16}), 32'd0);
        check("rst_in_ready4",   32'(in_ready4),   32'd1);
        check("rst_out_valid4",  32'(out_valid4),  32'd0);

        // Directed 16-bit vectors.
        issue16(16'h1234, 16'h0234, 16'h1000, 1'b0, 1'b0, 1'b0);
        issue16(16'h0000, 16'h0001, 16'hFFFF, 1'b1, 1'b0, 1'b0);
        issue16(16'h8000, 16'h0001, 16'h7FFF, 1'b0, 1'b1, 1'b0);
        issue16(16'hABCD, 16'hABCD, 16'h0000, 1'b0, 1'b0, 1'b1);
        issue16(16'h00F0, 16'h000F, 16'h00E1, 1'b0, 1'b0, 1'b0);

        // Backpressure: result held five cycles, in_valid pulses ignored.
        begin
            exp_t e;
            e.d = 16'h8000; e.b = 1'b1; e.o = 1'b1; e.z = 1'b0;
            q16.push_back(e);
            out_ready16 = 1'b0;
            send16(16'h7FFF, 16'hFFFF);
            wait_valid16();
            for (int i = 0; i < 5; i++) begin
                a16 = 16'h1111; b16 = 16'h2222; in_valid16 = 1'b1;
                tick();
                in_valid16 = 1'b0;
                check("stall_out_valid", 32'(out_valid16), 32'd1);
                check("stall_in_ready",  32'(in_ready16),  32'd0);
                check("stall_diff",      32'(diff16),      32'h8000);
                check("stall_flags",     32'({borrow16, ovf16, zero16}), 32'b110);
            end
            out_ready16 = 1'b1;
            tick();
            check("stall_release_out_valid", 32'(out_valid16), 32'd0);
            check("stall_release_in_ready",  32'(in_ready16),  32'd1);
        end
        issue16(16'h0010, 16'h0001, 16'h000F, 1'b0, 1'b0, 1'b0);

        // Reset mid-RUN with two nibbles done: operation discarded.
        send16(16'h9999, 16'h1111);
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_in_ready",  32'(in_ready16),  32'd1);
        check("abort_out_valid", 32'(out_valid16), 32'd0);
        check("abort_diff",      32'(diff16),      32'd0);
        check("abort_flags",     32'({borrow16, ovf16, zero16}), 32'd0);
        issue16(16'h0005, 16'h0003, 16'h0002, 1'b0, 1'b0, 1'b0);

        // 4-bit build: directed case then exhaustive sweep against a reference.
        issue4(4'h3, 4'h5, 4'hE, 1'b1, 1'b0, 1'b0);
        for (int ia = 0; ia < 16; ia++) begin
            for (int ib = 0; ib < 16; ib++) begin
                md = 4'((ia - ib) & 15);
                issue4(4'(ia), 4'(ib), md, (ia < ib),
                       ((ia >= 8) != (ib >= 8)) && ((md >= 4'd8) != (ia >= 8)),
                       (md == 4'd0));
            end
        end

        repeat (3) tick();
        check("w16_queue_drained", 32'(q16.size()), 32'd0);
        check("w4_queue_drained",  32'(q4.size()),  32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
